// File: rtl/discr_pulse_gen.sv
// Programmable pulse-train generator producing P_OUT_WIDTH discriminator bits per clock,
// bit 0 earliest; counted or continuous trains with completion and abort reporting.
module discr_pulse_gen #(
    parameter int unsigned P_OUT_WIDTH = 8,
    parameter int unsigned P_T_WIDTH   = 16,
    parameter int unsigned P_N_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [P_T_WIDTH-1:0]   period,
    input  logic [P_T_WIDTH-1:0]   width,
    input  logic [P_N_WIDTH-1:0]   n_pulses,
    output logic [P_OUT_WIDTH-1:0] a_out,
    output logic                   busy,
    output logic                   done,
    output logic [P_N_WIDTH-1:0]   n_sent
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [P_T_WIDTH-1:0] T_ONE      = {{(P_T_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_T_WIDTH-1:0] W_MAX      = {{(P_T_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [P_T_WIDTH:0]   TX_ONE     = {{P_T_WIDTH{1'b0}}, 1'b1};
    localparam logic [P_N_WIDTH:0]   K_ONE      = {{P_N_WIDTH{1'b0}}, 1'b1};
    localparam logic [P_N_WIDTH:0]   K_MAX_CONT = {1'b0, {P_N_WIDTH{1'b1}}};

    state_e                 state_q, state_d;
    logic [P_T_WIDTH-1:0]   w_q, w_d, p_q, p_d, pos_q, pos_d;
    logic [P_N_WIDTH-1:0]   n_q, n_d, n_sent_q, n_sent_d;
    logic [P_N_WIDTH:0]     k_q, k_d;
    logic [P_OUT_WIDTH-1:0] a_q, a_d;
    logic                   busy_q, busy_d, done_q, done_d;

    // Clamp so every period carries at least one high and one low bit.
    logic [P_T_WIDTH-1:0] w_clamp, w_plus1, p_clamp;
    always_comb begin
        w_clamp = (width == '0) ? T_ONE : width;
        if (w_clamp > W_MAX) w_clamp = W_MAX;
        w_plus1 = w_clamp + T_ONE;
        p_clamp = (period < w_plus1) ? w_plus1 : period;
    end

    logic [P_OUT_WIDTH-1:0] word;
    logic [P_T_WIDTH-1:0]   pos_v, pos_next;
    logic [P_T_WIDTH:0]     pos_inc;
    logic [P_N_WIDTH:0]     k_v, k_last, k_cap, n_ext;
    always_comb begin
        n_ext   = {1'b0, n_q};
        k_cap   = (n_q == '0) ? K_MAX_CONT : n_ext + K_ONE;
        pos_v   = pos_q;
        k_v     = k_q;
        pos_inc = '0;
        word    = '0;
        for (int j = 0; j < int'(P_OUT_WIDTH); j++) begin
            if (pos_v == '0 && k_v < k_cap) k_v = k_v + K_ONE;
            word[j] = (pos_v < w_q) && (n_q == '0 || k_v <= n_ext);
            pos_inc = {1'b0, pos_v} + TX_ONE;
            pos_v   = (pos_inc == {1'b0, p_q}) ? '0 : pos_inc[P_T_WIDTH-1:0];
        end
        pos_next = pos_v;
        k_last   = k_v;
    end

    // Last pulse is fully emitted once no pulse is mid-flight at the word boundary.
    logic complete;
    assign complete = (n_q != '0) &&
                      ((k_last > n_ext) ||
                       (k_last == n_ext && (pos_next == '0 || pos_next >= w_q)));

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        p_d      = p_q;
        n_d      = n_q;
        pos_d    = pos_q;
        k_d      = k_q;
        n_sent_d = n_sent_q;
        a_d      = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    w_d      = w_clamp;
                    p_d      = p_clamp;
                    n_d      = n_pulses;
                    pos_d    = '0;
                    k_d      = '0;
                    n_sent_d = '0;
                    busy_d   = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    a_d   = word;
                    pos_d = pos_next;
                    k_d   = k_last;
                    if (n_q == '0 || k_last <= n_ext) n_sent_d = k_last[P_N_WIDTH-1:0];
                    else                              n_sent_d = n_q;
                    if (complete) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            w_q      <= '0;
            p_q      <= '0;
            n_q      <= '0;
            pos_q    <= '0;
            k_q      <= '0;
            n_sent_q <= '0;
            a_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            p_q      <= p_d;
            n_q      <= n_d;
            pos_q    <= pos_d;
            k_q      <= k_d;
            n_sent_q <= n_sent_d;
            a_q      <= a_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a_out  = a_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign n_sent = n_sent_q;

endmodule

// File: doc/discr_pulse_gen.md
# discr_pulse_gen

Programmable pulse-train generator that drives a parallel discriminator bitstream of P_OUT_WIDTH bits per clock, bit 0 earliest in time. It is the transmit side of the discriminator scaler path. Typical uses:
- muxed in ahead of the scaler for self-test;
- driven into the trigger logic as a fake-hit source.

It emits a configured number of fixed-width pulses at a fixed bit-time period, or runs continuously, and reports completion.

## Interface
- P_OUT_WIDTH, 8: bitstream bits per clock.
- P_T_WIDTH, 16: width of the period and pulse-width fields, in bit-times.
- P_N_WIDTH, 32: width of the pulse-count fields.
- clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request; honored only in IDLE.
- stop  in  1  abort; honored in RUN; wins over start in the same cycle.
- period  in  P_T_WIDTH  bit-times between rising edges; latched on start.
- width  in  P_T_WIDTH  high bit-times per pulse; latched on start.
- n_pulses  in  P_N_WIDTH  pulses per train; 0 means continuous; latched on start.
- a_out  out  P_OUT_WIDTH  registered bitstream word; bit 0 is earliest.
- busy  out  1  registered; 1 while in RUN.
- done  out  1  registered single-cycle pulse when a train ends, whether completed or aborted.
- n_sent  out  P_N_WIDTH  pulses started in the current or last train, capped at n_pulses when n_pulses≠0.

## Operation
- States are IDLE and RUN. In IDLE, a_out=0.
- On start in IDLE, the block latches clamped parameters:
  - w = max(width,1), capped at 2^P_T_WIDTH−2.
  - p = max(period, w+1), which guarantees at least 1 low bit per period.
- On the same start it clears pos=0, k=0 and n_sent=0, and enters RUN.
- Per RUN cycle, it computes one bit position per output bit j:
  - pos_0 = pos; pos_{j+1} = (pos_j+1 == p) ? 0 : pos_j+1.
  - pos_next is the same recurrence applied after bit P_OUT_WIDTH−1.
- k_j = k + (number of i ≤ j with pos_i == 0), i.e. pulses started through bit j. k saturates at n_pulses+1; in continuous mode it saturates at all-ones.
- Bit j is 1 iff pos_j < w and (n_pulses==0 or k_j ≤ n_pulses). The mask suppresses any pulse past the count entirely; there is no partial pulse.
- At the clock edge: a_out ← word; pos ← pos_next; k ← k_last, where k_last = k_{P_OUT_WIDTH−1}; n_sent ← min(k_last, n_pulses), or k_last in continuous mode.
- The train is complete when n_pulses≠0 and either:
  - k_last > n_pulses, or
  - k_last == n_pulses and (pos_next == 0 or pos_next ≥ w).
- On completion at that edge: state→IDLE, busy←0, done←1. done coincides with the final word; a_out returns to 0 on the following edge.
- stop in RUN: a_out←0, state→IDLE, busy←0, done←1 at that edge. The pulse in flight is truncated. n_sent holds its value.
- start while in RUN is ignored. Parameter changes while in RUN are ignored.
- With start and stop both asserted in IDLE, the block stays in IDLE and done stays 0.
- p < P_OUT_WIDTH is legal: several pulses per word.

## Timing
- Reset values: a_out=0, busy=0, done=0, n_sent=0, state IDLE, pos=0, k=0.
- start is sampled at edge E. busy=1 after E. Word 0, containing the rising edge at bit 0, appears on a_out after E+1.
- Because the IDLE word was 0, word 0 always presents a positive edge at bit 0 to a downstream edge counter.
- Continuous mode runs until stop or i_rst.
- i_rst mid-train: at that edge all outputs go to their reset values; done is not asserted.
- Back-to-back trains: start is accepted in the cycle after done. The new word 0 then follows the all-zero IDLE word.
- Rising-edge count over a full train equals n_pulses, provided the downstream counter carries the last bit across words.

## Test plan
- w=3, p=10, n=2:
  - a_out = 8'h07 then 8'h1C, with done=1 and busy→0 alongside 8'h1C.
  - Next word is 8'h00; n_sent=2.
- w=1, p=2, n=3: single word 8'h15 (the 4th pulse is masked), with done on the same cycle; n_sent=3.
- width=0, period=0, n=0 (clamped to w=1, p=2): continuous 8'h55 words. stop → next a_out=8'h00, done pulses once, busy=0.
- Loopback into the scaler:
  - Setup: w=2, p=5, n=0, scaler period 1000.
  - Each valid window reports 1600 edges (8000 bits / 5).
- Abort and reset:
  - w=8, p=20, n=0: assert stop in the cycle after the 8'hFF word → 8'h00, done=1.
  - Repeat the run and assert i_rst instead → all outputs 0, no done.
- start with stop in IDLE: no RUN, no done. start while in RUN with new parameters: the current train is unaffected.
